id_ex_stage: RTL and testbench

- Decode-to-execute pipeline register for the five-stage RISC-V core; it directly feeds the ALU.
- Latches decoded operands and control, then applies MEM/WB operand forwarding to drive the ALU A/B inputs and ALUControl.
- Handles stall (hold), flush (bubble insertion) and load-use hazard detection for the hazard unit.

---
 rtl/id_ex_stage.sv | 153 +++++++++++++++
 tb/tb_id_ex_stage.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the five-stage RISC-V core.
// Captures decoded operands and control, applies MEM/WB operand forwarding
// to produce the ALU inputs, and flags load-use hazards for the hazard unit.
module id_ex_stage #(
   parameter int XLEN   = 32,
   parameter bit FWD_EN = 1'b1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            stall_e,
   input  logic            flush_e,
   input  logic            valid_d,
   input  logic [XLEN-1:0] rd1_d,
   input  logic [XLEN-1:0] rd2_d,
   input  logic [XLEN-1:0] imm_ext_d,
   input  logic [XLEN-1:0] pc_d,
   input  logic [XLEN-1:0] pc_plus4_d,
   input  logic [4:0]      rs1_d,
   input  logic [4:0]      rs2_d,
   input  logic [4:0]      rd_d,
   input  logic [2:0]      alu_control_d,
   input  logic            alu_src_d,
   input  logic            reg_write_d,
   input  logic            mem_write_d,
   input  logic            branch_d,
   input  logic            jump_d,
   input  logic [1:0]      result_src_d,
   input  logic [XLEN-1:0] alu_result_m,
   input  logic [XLEN-1:0] result_w,
   input  logic [4:0]      rd_m,
   input  logic [4:0]      rd_w,
   input  logic            reg_write_m,
   input  logic            reg_write_w,
   output logic [XLEN-1:0] src_a_e,
   output logic [XLEN-1:0] src_b_e,
   output logic [XLEN-1:0] write_data_e,
   output logic [2:0]      alu_control_e,
   output logic [XLEN-1:0] pc_target_e,
   output logic [XLEN-1:0] pc_plus4_e,
   output logic [4:0]      rd_e,
   output logic [4:0]      rs1_e,
   output logic [4:0]      rs2_e,
   output logic            reg_write_e,
   output logic            mem_write_e,
   output logic            branch_e,
   output logic            jump_e,
   output logic            valid_e,
   output logic [1:0]      result_src_e,
   output logic            lwstall
);

   logic [XLEN-1:0] rd1_q, rd2_q, imm_q, pc_q, pc_plus4_q;
   logic [4:0]      rs1_q, rs2_q, rd_q;
   logic [2:0]      alu_control_q;
   logic            alu_src_q, reg_write_q, mem_write_q, branch_q, jump_q, valid_q;
   logic [1:0]      result_src_q;

   logic [XLEN-1:0] fwd_a, fwd_b;

   // E-stage register: reset > flush (bubble) > stall (hold) > load
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd1_q         <= '0;
         rd2_q         <= '0;
         imm_q         <= '0;
         pc_q          <= '0;
         pc_plus4_q    <= '0;
         rs1_q         <= '0;
         rs2_q         <= '0;
         rd_q          <= '0;
         alu_control_q <= '0;
         alu_src_q     <= 1'b0;
         reg_write_q   <= 1'b0;
         mem_write_q   <= 1'b0;
         branch_q      <= 1'b0;
         jump_q        <= 1'b0;
         valid_q       <= 1'b0;
         result_src_q  <= '0;
      end else if (flush_e) begin
         rd1_q         <= '0;
         rd2_q         <= '0;
         imm_q         <= '0;
         pc_q          <= '0;
         pc_plus4_q    <= '0;
         rs1_q         <= '0;
         rs2_q         <= '0;
         rd_q          <= '0;
         alu_control_q <= '0;
         alu_src_q     <= 1'b0;
         reg_write_q   <= 1'b0;
         mem_write_q   <= 1'b0;
         branch_q      <= 1'b0;
         jump_q        <= 1'b0;
         valid_q       <= 1'b0;
         result_src_q  <= '0;
      end else if (!stall_e) begin
         rd1_q         <= rd1_d;
         rd2_q         <= rd2_d;
         imm_q         <= imm_ext_d;
         pc_q          <= pc_d;
         pc_plus4_q    <= pc_plus4_d;
         rs1_q         <= rs1_d;
         rs2_q         <= rs2_d;
         rd_q          <= rd_d;
         alu_control_q <= alu_control_d;
         alu_src_q     <= alu_src_d;
         // an invalid decode slot must never cause architectural side effects
         reg_write_q   <= reg_write_d & valid_d;
         mem_write_q   <= mem_write_d & valid_d;
         branch_q      <= branch_d & valid_d;
         jump_q        <= jump_d & valid_d;
         valid_q       <= valid_d;
         result_src_q  <= result_src_d;
      end
   end

   // Operand forwarding: MEM beats WB, x0 is never forwarded
   always_comb begin
      fwd_a = rd1_q;
      fwd_b = rd2_q;
      if (FWD_EN) begin
         if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs1_q))
            fwd_a = alu_result_m;
         else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs1_q))
            fwd_a = result_w;
         if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs2_q))
            fwd_b = alu_result_m;
         else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs2_q))
            fwd_b = result_w;
      end
   end

   assign src_a_e       = fwd_a;
   assign write_data_e  = fwd_b;
   assign src_b_e       = alu_src_q ? imm_q : fwd_b;
   assign pc_target_e   = pc_q + imm_q;
   assign pc_plus4_e    = pc_plus4_q;
   assign alu_control_e = alu_control_q;
   assign rd_e          = rd_q;
   assign rs1_e         = rs1_q;
   assign rs2_e         = rs2_q;
   assign reg_write_e   = reg_write_q;
   assign mem_write_e   = mem_write_q;
   assign branch_e      = branch_q;
   assign jump_e        = jump_q;
   assign valid_e       = valid_q;
   assign result_src_e  = result_src_q;

   // Load in E whose destination is read by the instruction in D
   assign lwstall = valid_q && (result_src_q == 2'b01) && (rd_q != 5'd0) &&
                    ((rd_q == rs1_d) || (rd_q == rs2_d));

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed test-plan steps plus random traffic,
// checked against a behavioural model of the E-stage contents.
module tb_id_ex_stage;

   localparam int XLEN = 32;

   logic            clk = 1'b0;
   logic            reset, stall_e, flush_e, valid_d;
   logic [XLEN-1:0] rd1_d, rd2_d, imm_ext_d, pc_d, pc_plus4_d;
   logic [4:0]      rs1_d, rs2_d, rd_d;
   logic [2:0]      alu_control_d;
   logic            alu_src_d, reg_write_d, mem_write_d, branch_d, jump_d;
   logic [1:0]      result_src_d;
   logic [XLEN-1:0] alu_result_m, result_w;
   logic [4:0]      rd_m, rd_w;
   logic            reg_write_m, reg_write_w;

   logic [XLEN-1:0] src_a_e, src_b_e, write_data_e, pc_target_e, pc_plus4_e;
   logic [2:0]      alu_control_e;
   logic [4:0]      rd_e, rs1_e, rs2_e;
   logic            reg_write_e, mem_write_e, branch_e, jump_e, valid_e, lwstall;
   logic [1:0]      result_src_e;

   logic [XLEN-1:0] nf_src_a, nf_src_b, nf_wd, nf_pct, nf_pc4;
   logic [2:0]      nf_aluc;
   logic [4:0]      nf_rd, nf_rs1, nf_rs2;
   logic            nf_rw, nf_mw, nf_br, nf_j, nf_v, nf_lw;
   logic [1:0]      nf_rs;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   id_ex_stage #(.XLEN(XLEN), .FWD_EN(1'b1)) dut (
      .clk(clk), .reset(reset), .stall_e(stall_e), .flush_e(flush_e), .valid_d(valid_d),
      .rd1_d(rd1_d), .rd2_d(rd2_d), .imm_ext_d(imm_ext_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d),
      .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d), .alu_control_d(alu_control_d),
      .alu_src_d(alu_src_d), .reg_write_d(reg_write_d), .mem_write_d(mem_write_d),
      .branch_d(branch_d), .jump_d(jump_d), .result_src_d(result_src_d),
      .alu_result_m(alu_result_m), .result_w(result_w), .rd_m(rd_m), .rd_w(rd_w),
      .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
      .src_a_e(src_a_e), .src_b_e(src_b_e), .write_data_e(write_data_e),
      .alu_control_e(alu_control_e), .pc_target_e(pc_target_e), .pc_plus4_e(pc_plus4_e),
      .rd_e(rd_e), .rs1_e(rs1_e), .rs2_e(rs2_e), .reg_write_e(reg_write_e),
      .mem_write_e(mem_write_e), .branch_e(branch_e), .jump_e(jump_e), .valid_e(valid_e),
      .result_src_e(result_src_e), .lwstall(lwstall)
   );

   id_ex_stage #(.XLEN(XLEN), .FWD_EN(1'b0)) dut_nf (
      .clk(clk), .reset(reset), .stall_e(stall_e), .flush_e(flush_e), .valid_d(valid_d),
      .rd1_d(rd1_d), .rd2_d(rd2_d), .imm_ext_d(imm_ext_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d),
      .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d), .alu_control_d(alu_control_d),
      .alu_src_d(alu_src_d), .reg_write_d(reg_write_d), .mem_write_d(mem_write_d),
      .branch_d(branch_d), .jump_d(jump_d), .result_src_d(result_src_d),
      .alu_result_m(alu_result_m), .result_w(result_w), .rd_m(rd_m), .rd_w(rd_w),
      .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
      .src_a_e(nf_src_a), .src_b_e(nf_src_b), .write_data_e(nf_wd),
      .alu_control_e(nf_aluc), .pc_target_e(nf_pct), .pc_plus4_e(nf_pc4),
      .rd_e(nf_rd), .rs1_e(nf_rs1), .rs2_e(nf_rs2), .reg_write_e(nf_rw),
      .mem_write_e(nf_mw), .branch_e(nf_br), .jump_e(nf_j), .valid_e(nf_v),
      .result_src_e(nf_rs), .lwstall(nf_lw)
   );

   // Model: the instruction currently sitting in E, as a record
   typedef struct {
      logic [31:0] a, b, imm, pc, pc4;
      logic [4:0]  rs1, rs2, rd;
      logic [2:0]  op;
      logic        use_imm, rw, mw, br, j, v;
      logic [1:0]  rsrc;
   } instr_t;

   instr_t m;

   function automatic instr_t bubble();
      instr_t b;
      b = '{a:0, b:0, imm:0, pc:0, pc4:0, rs1:0, rs2:0, rd:0, op:0,
            use_imm:0, rw:0, mw:0, br:0, j:0, v:0, rsrc:0};
      return b;
   endfunction

   // Value of register idx as seen by E, given in-flight MEM/WB writers
   function automatic logic [31:0] operand(input logic [4:0] idx, input logic [31:0] rf,
                                           input bit fwd);
      if (fwd && idx != 0 && reg_write_m && rd_m == idx) return alu_result_m;
      if (fwd && idx != 0 && reg_write_w && rd_w == idx) return result_w;
      return rf;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic check_all(input string tag);
      logic [31:0] wd, wd_nf;
      bit          lu;
      wd    = operand(m.rs2, m.b, 1);
      wd_nf = m.b;
      lu    = m.v && m.rsrc == 2'b01 && m.rd != 0 && (m.rd == rs1_d || m.rd == rs2_d);
      chk({tag, ".src_a"},     src_a_e,      operand(m.rs1, m.a, 1));
      chk({tag, ".src_b"},     src_b_e,      m.use_imm ? m.imm : wd);
      chk({tag, ".wdata"},     write_data_e, wd);
      chk({tag, ".nf_src_a"},  nf_src_a,     m.a);
      chk({tag, ".nf_src_b"},  nf_src_b,     m.use_imm ? m.imm : wd_nf);
      chk({tag, ".pc_target"}, pc_target_e,  m.pc + m.imm);
      chk({tag, ".pc4"},       pc_plus4_e,   m.pc4);
      chk({tag, ".aluctl"},    {29'd0, alu_control_e}, {29'd0, m.op});
      chk({tag, ".idx"},       {17'd0, rd_e, rs1_e, rs2_e}, {17'd0, m.rd, m.rs1, m.rs2});
      chk({tag, ".ctl"},       {26'd0, reg_write_e, mem_write_e, branch_e, jump_e, valid_e, 1'b0},
                               {26'd0, m.rw, m.mw, m.br, m.j, m.v, 1'b0});
      chk({tag, ".rsrc"},      {30'd0, result_src_e}, {30'd0, m.rsrc});
      chk({tag, ".lwstall"},   {31'd0, lwstall}, {31'd0, lu});
   endtask

   // Advance one clock and update the model with what the edge should do
   task automatic step();
      @(posedge clk);
      if (!reset) begin
         if (flush_e) m = bubble();
         else if (!stall_e) begin
            m.a = rd1_d; m.b = rd2_d; m.imm = imm_ext_d; m.pc = pc_d; m.pc4 = pc_plus4_d;
            m.rs1 = rs1_d; m.rs2 = rs2_d; m.rd = rd_d; m.op = alu_control_d;
            m.use_imm = alu_src_d; m.v = valid_d; m.rsrc = result_src_d;
            m.rw = reg_write_d && valid_d; m.mw = mem_write_d && valid_d;
            m.br = branch_d && valid_d;   m.j = jump_d && valid_d;
         end
      end
      #1;
   endtask

   task automatic rand_d();
      valid_d = ($urandom_range(0, 3) != 0);
      rd1_d = $urandom; rd2_d = $urandom; imm_ext_d = $urandom;
      pc_d = $urandom; pc_plus4_d = pc_d + 4;
      rs1_d = 5'($urandom_range(0, 7)); rs2_d = 5'($urandom_range(0, 7));
      rd_d  = 5'($urandom_range(0, 7));
      alu_control_d = 3'($urandom); alu_src_d = 1'($urandom);
      reg_write_d = 1'($urandom); mem_write_d = 1'($urandom);
      branch_d = 1'($urandom); jump_d = 1'($urandom);
      result_src_d = 2'($urandom_range(0, 2));
   endtask

   task automatic rand_mw();
      alu_result_m = $urandom; result_w = $urandom;
      rd_m = 5'($urandom_range(0, 7)); rd_w = 5'($urandom_range(0, 7));
      reg_write_m = 1'($urandom); reg_write_w = 1'($urandom);
   endtask

   task automatic quiet_mw();
      reg_write_m = 0; reg_write_w = 0; rd_m = 0; rd_w = 0;
      alu_result_m = 0; result_w = 0;
   endtask

   logic [31:0] frz_a, frz_pc4;
   logic [4:0]  frz_rd;

   initial begin
      m = bubble();
      reset = 1; stall_e = 0; flush_e = 0;
      rand_d(); rand_mw();
      #12 reset = 0;
      check_all("por");

      // 1: reset during traffic, no edge needed
      for (int i = 0; i < 5; i++) begin rand_d(); rand_mw(); step(); check_all("pre_rst"); end
      #2 reset = 1; m = bubble();
      #1;
      quiet_mw(); rs1_d = 0; rs2_d = 0;
      check_all("async_rst");
      chk("rst.src_a", src_a_e, 32'd0);
      chk("rst.pct",   pc_target_e, 32'd0);
      rand_d(); valid_d = 1; rd1_d = 5; rd2_d = 7; alu_control_d = 3'b000; alu_src_d = 0;
      rs1_d = 1; rs2_d = 2; rd_d = 9; result_src_d = 0;
      #2 reset = 0;
      step();
      check_all("after_rst");
      chk("t1.src_a", src_a_e, 32'd5);
      chk("t1.src_b", src_b_e, 32'd7);
      chk("t1.aluc",  {29'd0, alu_control_e}, 32'd0);

      // 2: forwarding priority
      rand_d(); rs1_d = 3; rs2_d = 4; rd1_d = 32'hA; rd2_d = 32'hB; alu_src_d = 0; valid_d = 1;
      step();
      rd_m = 3; reg_write_m = 1; alu_result_m = 32'h11;
      rd_w = 3; reg_write_w = 1; result_w = 32'h22;
      #1 check_all("fwd_mem_wins");
      chk("t2.src_a", src_a_e, 32'h11);
      chk("t2.nf_a",  nf_src_a, 32'hA);
      rd_w = 4;
      #1 check_all("fwd_wb_b");
      chk("t2.src_b", src_b_e, 32'h22);
      chk("t2.nf_b",  nf_src_b, 32'hB);

      // 3: x0 never forwarded
      rs1_d = 0; rd1_d = 0; rs2_d = 0; rd2_d = 0;
      step();
      rd_m = 0; reg_write_m = 1; alu_result_m = 32'hDEAD; rd_w = 0; reg_write_w = 1;
      #1 check_all("x0");
      chk("t3.src_a", src_a_e, 32'd0);

      // 4: stall holds while D changes, then flush beats stall
      quiet_mw(); rand_d(); valid_d = 1; reg_write_d = 1; mem_write_d = 1; rd_d = 5;
      step();
      frz_a = src_a_e; frz_pc4 = pc_plus4_e; frz_rd = rd_e;
      stall_e = 1;
      for (int i = 0; i < 3; i++) begin rand_d(); step(); check_all("stall"); end
      chk("t4.frz_a", src_a_e, frz_a);
      chk("t4.frz_pc4", pc_plus4_e, frz_pc4);
      chk("t4.frz_rd", {27'd0, rd_e}, {27'd0, frz_rd});
      flush_e = 1;
      step();
      check_all("flush_stall");
      chk("t4.bubble", {24'd0, valid_e, reg_write_e, mem_write_e, rd_e}, 32'd0);
      stall_e = 0; flush_e = 0;

      // 5: load-use detection
      rand_d(); valid_d = 1; result_src_d = 2'b01; rd_d = 6;
      step();
      rs1_d = 1; rs2_d = 6;
      #1 check_all("lu_hit");
      chk("t5.hit", {31'd0, lwstall}, 32'd1);
      rs2_d = 7;
      #1 chk("t5.miss", {31'd0, lwstall}, 32'd0);
      rs1_d = 6;
      #1 chk("t5.rs1hit", {31'd0, lwstall}, 32'd1);
      result_src_d = 2'b01; rd_d = 0; valid_d = 1;
      step();
      rs1_d = 0; rs2_d = 0;
      #1 check_all("lu_rd0");
      chk("t5.rd0", {31'd0, lwstall}, 32'd0);
      rd_d = 6; step();
      flush_e = 1; step(); flush_e = 0;
      rs1_d = 6; rs2_d = 6;
      #1 chk("t5.flushed", {31'd0, lwstall}, 32'd0);

      // 6: immediate operand, branch target wrap, invalid-slot sanitising
      rand_d(); alu_src_d = 1; imm_ext_d = 32'hFFFF_FFFC; pc_d = 32'h100;
      valid_d = 0; reg_write_d = 1; mem_write_d = 1; branch_d = 1; jump_d = 1;
      step();
      check_all("imm");
      chk("t6.src_b", src_b_e, 32'hFFFF_FFFC);
      chk("t6.pct",   pc_target_e, 32'hFC);
      chk("t6.rw",    {31'd0, reg_write_e}, 32'd0);

      // Random traffic with occasional stall/flush and reset
      for (int i = 0; i < 300; i++) begin
         rand_d(); rand_mw();
         stall_e = ($urandom_range(0, 4) == 0);
         flush_e = ($urandom_range(0, 9) == 0);
         step();
         check_all("rand");
         rand_mw();
         #1 check_all("rand_fwd");
         if ($urandom_range(0, 49) == 0) begin
            reset = 1; m = bubble();
            #1 check_all("rand_rst");
            reset = 0;
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
